instr_fetch: RTL and testbench

- Fetch-stage initiator for the 16-bit CPU. Owns the program counter and drives the combinational instruction ROM address, `imem_pc`. Captures the returned word into the IF/ID pipeline register.
- Handles three control events: stall from hazard logic, redirect from branch resolution in EX, and halt when the PC runs past the end of the ROM.
- The ROM sits outside this block. The top level wires `imem_pc` to the ROM `pc` input and the ROM `instruction` output to `imem_instr`.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_pc_sel.sv | 103 ++++++++++
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned PC_WIDTH_DEF    = 16;
  localparam int unsigned INSTR_WIDTH_DEF = 16;
  localparam int unsigned PC_STEP         = 2;
  localparam logic [15:0] NOP_INSTR       = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// Combinational next-PC / next-state selector for the fetch stage.
// Priority in RUN: redirect > past end of ROM > stall > sequential fetch.
// INSTR_FETCH_MISALIGN_TRAP_EN: odd redirect targets halt fetch instead of
// being silently aligned.
module fetch_pc_sel
  import fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = PC_WIDTH_DEF,
  parameter int unsigned ROM_LIMIT = 32
) (
  input  fetch_state_t          state_q,
  input  logic [PC_WIDTH-1:0]   pc_q,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  input  logic                  fault_q,
  output logic                  set_fault,
`endif
  output fetch_state_t          state_d,
  output logic [PC_WIDTH-1:0]   pc_d,
  output logic                  capture,
  output logic                  flush
);

  logic [PC_WIDTH-1:0] target;
  logic                past_end;
  logic                misalign;
  logic                locked;

  assign target   = {redirect_pc[PC_WIDTH-1:1], 1'b0};
  assign past_end = {1'b0, pc_q} >= (PC_WIDTH+1)'(ROM_LIMIT);

`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  assign misalign = redirect_pc[0];
  assign locked   = fault_q;
`else
  logic unused_lsb;
  assign unused_lsb = redirect_pc[0];
  assign misalign   = 1'b0;
  assign locked     = 1'b0;
`endif

  // Select next state/PC and the IF/ID update action for this edge.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    flush   = 1'b0;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    set_fault = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        state_d = RUN;
        if (redirect_valid) begin
          if (misalign) begin
            state_d = HALT;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
            set_fault = 1'b1;
`endif
          end else begin
            pc_d = target;
          end
        end
      end
      RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (misalign) begin
            state_d = HALT;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
            set_fault = 1'b1;
`endif
          end else begin
            pc_d = target;
          end
        end else if (past_end) begin
          state_d = HALT;
          flush   = 1'b1;
        end else if (!stall) begin
          capture = 1'b1;
          pc_d    = pc_q + PC_WIDTH'(PC_STEP);
        end
      end
      HALT: begin
        // A latched misalignment fault keeps fetch halted until reset.
        if (redirect_valid && !locked) begin
          if (misalign) begin
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
            set_fault = 1'b1;
`endif
          end else begin
            pc_d    = target;
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the ROM address and holds IF/ID.
// Optional macro INSTR_FETCH_MISALIGN_TRAP_EN adds the misalign_fault output.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned          PC_WIDTH    = PC_WIDTH_DEF,
  parameter int unsigned          INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
  parameter int unsigned          ROM_LIMIT   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [PC_WIDTH-1:0]    imem_pc,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  output logic                   ifid_valid,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [PC_WIDTH-1:0]    ifid_pc,
  output logic [PC_WIDTH-1:0]    ifid_pc_plus2,
  output logic                   halted,
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  output logic                   misalign_fault,
`endif
  output logic [15:0]            fetch_count
);

  fetch_state_t           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    ipc_q, ipc_d;
  logic [PC_WIDTH-1:0]    ipc2_q, ipc2_d;
  logic [15:0]            count_q, count_d;
  logic                   capture, flush;

`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d, set_fault;
`endif

  fetch_pc_sel #(
    .PC_WIDTH  (PC_WIDTH),
    .ROM_LIMIT (ROM_LIMIT)
  ) u_sel (
    .state_q        (state_q),
    .pc_q           (pc_q),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    .fault_q        (fault_q),
    .set_fault      (set_fault),
`endif
    .state_d        (state_d),
    .pc_d           (pc_d),
    .capture        (capture),
    .flush          (flush)
  );

  // IF/ID register and fetch counter next values.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc2_d  = ipc2_q;
    count_d = count_q;
    if (capture) begin
      valid_d = 1'b1;
      instr_d = imem_instr;
      ipc_d   = pc_q;
      ipc2_d  = pc_q + PC_WIDTH'(PC_STEP);
      if (count_q != '1) count_d = count_q + 16'd1;
    end else if (flush) begin
      valid_d = 1'b0;
    end
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    fault_d = fault_q | set_fault;
`endif
  end

  // State, PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= INSTR_WIDTH'(NOP_INSTR);
      ipc_q   <= '0;
      ipc2_q  <= '0;
      count_q <= '0;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc2_q  <= ipc2_d;
      count_q <= count_d;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign imem_pc       = pc_q;
  assign ifid_valid    = valid_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc       = ipc_q;
  assign ifid_pc_plus2 = ipc2_q;
  assign halted        = (state_q == HALT);
  assign fetch_count   = count_q;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  assign misalign_fault = fault_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector bench for instr_fetch with a 16-word behavioural ROM.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [15:0] redirect_pc, imem_pc, imem_instr;
  logic        ifid_valid, halted;
  logic [15:0] ifid_instr, ifid_pc, ifid_pc_plus2, fetch_count;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  logic        misalign_fault;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [15:0] rom [16];

  always #5 clk = ~clk;

  always_comb begin
    imem_instr = 16'h0000;
    if (imem_pc < 16'd32) imem_instr = rom[imem_pc[4:1]];
  end

  instr_fetch #(
    .PC_WIDTH    (16),
    .INSTR_WIDTH (16),
    .RESET_PC    (16'h0000),
    .ROM_LIMIT   (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus2  (ifid_pc_plus2),
    .halted         (halted),
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    .misalign_fault (misalign_fault),
`endif
    .fetch_count    (fetch_count)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rv;
    logic [15:0] rpc;
    logic        ev;
    logic [15:0] ei;
    logic [15:0] epc;
    logic [15:0] eimem;
    logic        eh;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rst, logic stl, logic rv, logic [15:0] rpc,
                              logic ev, logic [15:0] ei, logic [15:0] epc,
                              logic [15:0] eimem, logic eh, logic [15:0] ecnt);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.ei = ei; v.epc = epc; v.eimem = eimem; v.eh = eh; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic stl, input logic rv,
                      input logic [15:0] rpc);
    reset = rst; stall = stl; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned seen;
    logic [15:0] last_pc;
    bit          got_halt;

    rom[0] = 16'h8180; rom[1] = 16'h2CB2; rom[2] = 16'h4A11;
    rom[3] = 16'h6B22; rom[4] = 16'h1C33; rom[5] = 16'hE0F6;
    for (int i = 6; i < 16; i++) rom[i] = 16'hA000 + 16'(i);

    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // reset, IDLE, first fetches
    vt.push_back(mk(1,0,0,16'h0000, 0,16'h0000,16'h0000,16'h0000,0,16'd0));
    vt.push_back(mk(0,0,0,16'h0000, 0,16'h0000,16'h0000,16'h0000,0,16'd0));
    vt.push_back(mk(0,0,0,16'h0000, 1,16'h8180,16'h0000,16'h0002,0,16'd1));
    vt.push_back(mk(0,0,0,16'h0000, 1,16'h2CB2,16'h0002,16'h0004,0,16'd2));
    vt.push_back(mk(0,0,0,16'h0000, 1,16'h4A11,16'h0004,16'h0006,0,16'd3));
    // three stalled edges hold everything
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(0,1,0,16'h0000, 1,16'h4A11,16'h0004,16'h0006,0,16'd3));
    vt.push_back(mk(0,0,0,16'h0000, 1,16'h6B22,16'h0006,16'h0008,0,16'd4));
    // redirect overrides stall and flushes
    vt.push_back(mk(0,1,1,16'h0002, 0,16'h0000,16'h0000,16'h0002,0,16'd4));
    vt.push_back(mk(0,0,0,16'h0000, 1,16'h2CB2,16'h0002,16'h0004,0,16'd5));
    vt.push_back(mk(0,0,0,16'h0000, 1,16'h4A11,16'h0004,16'h0006,0,16'd6));
    // run to the end of the ROM
    for (int k = 0; k < 13; k++)
      vt.push_back(mk(0,0,0,16'h0000, 1,rom[3+k],16'(6+2*k),16'(8+2*k),0,16'(7+k)));
    vt.push_back(mk(0,0,0,16'h0000, 0,16'h0000,16'h0000,16'h0020,1,16'd19));
    vt.push_back(mk(0,1,0,16'h0000, 0,16'h0000,16'h0000,16'h0020,1,16'd19));
    // redirect out of HALT
    vt.push_back(mk(0,0,1,16'h0000, 0,16'h0000,16'h0000,16'h0000,0,16'd19));
    vt.push_back(mk(0,0,0,16'h0000, 1,16'h8180,16'h0000,16'h0002,0,16'd20));
    vt.push_back(mk(0,0,0,16'h0000, 1,16'h2CB2,16'h0002,16'h0004,0,16'd21));
    vt.push_back(mk(0,0,0,16'h0000, 1,16'h4A11,16'h0004,16'h0006,0,16'd22));
    vt.push_back(mk(0,0,0,16'h0000, 1,16'h6B22,16'h0006,16'h0008,0,16'd23));
    vt.push_back(mk(0,0,0,16'h0000, 1,16'h1C33,16'h0008,16'h000A,0,16'd24));
    // reset at pc=10 wins over stall and redirect
    vt.push_back(mk(1,1,1,16'h0006, 0,16'h0000,16'h0000,16'h0000,0,16'd0));
    vt.push_back(mk(0,0,0,16'h0000, 0,16'h0000,16'h0000,16'h0000,0,16'd0));
    vt.push_back(mk(0,0,0,16'h0000, 1,16'h8180,16'h0000,16'h0002,0,16'd1));
    // odd redirect target
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    vt.push_back(mk(0,0,1,16'h0005, 0,16'h0000,16'h0000,16'h0002,1,16'd1));
    vt.push_back(mk(0,0,0,16'h0000, 0,16'h0000,16'h0000,16'h0002,1,16'd1));
    vt.push_back(mk(0,0,1,16'h0000, 0,16'h0000,16'h0000,16'h0002,1,16'd1));
`else
    vt.push_back(mk(0,0,1,16'h0005, 0,16'h0000,16'h0000,16'h0004,0,16'd1));
    vt.push_back(mk(0,0,0,16'h0000, 1,16'h4A11,16'h0004,16'h0006,0,16'd2));
    vt.push_back(mk(0,0,1,16'h0000, 0,16'h0000,16'h0000,16'h0000,0,16'd2));
`endif

    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].stl, vt[i].rv, vt[i].rpc);
      chk("ifid_valid", i, 16'(ifid_valid), 16'(vt[i].ev));
      chk("imem_pc", i, imem_pc, vt[i].eimem);
      chk("halted", i, 16'(halted), 16'(vt[i].eh));
      chk("fetch_count", i, fetch_count, vt[i].ecnt);
      if (vt[i].ev) begin
        chk("ifid_instr", i, ifid_instr, vt[i].ei);
        chk("ifid_pc", i, ifid_pc, vt[i].epc);
        chk("ifid_pc_plus2", i, ifid_pc_plus2, vt[i].epc + 16'd2);
      end else if (vt[i].rst) begin
        chk("rst_instr", i, ifid_instr, 16'h0000);
        chk("rst_pc", i, ifid_pc, 16'h0000);
        chk("rst_pc_plus2", i, ifid_pc_plus2, 16'h0000);
      end
    end

`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    chk("misalign_fault", 0, 16'(misalign_fault), 16'h0001);
    step(1,0,0,16'h0000);
    chk("misalign_fault_rst", 0, 16'(misalign_fault), 16'h0000);
`endif

    // redirect past the ROM from IDLE re-enters HALT on the next edge
    step(1,0,0,16'h0000);
    step(0,0,1,16'h0028);
    chk("seq_far_pc", 100, imem_pc, 16'h0028);
    chk("seq_far_run", 100, 16'(halted), 16'h0000);
    step(0,0,0,16'h0000);
    chk("seq_far_halt", 101, 16'(halted), 16'h0001);
    chk("seq_far_valid", 101, 16'(ifid_valid), 16'h0000);

    // restart near the end, bounded wait for halt
    step(0,0,1,16'h001C);
    chk("seq_tail_pc", 102, imem_pc, 16'h001C);
    chk("seq_tail_run", 102, 16'(halted), 16'h0000);
    seen = 0; last_pc = '0; got_halt = 1'b0;
    for (int c = 0; c < 10 && !got_halt; c++) begin
      step(0,0,0,16'h0000);
      if (ifid_valid) begin
        seen++;
        last_pc = ifid_pc;
      end
      if (halted) got_halt = 1'b1;
    end
    chk("seq_tail_halt_seen", 103, 16'(got_halt), 16'h0001);
    chk("seq_tail_fetches", 103, 16'(seen), 16'h0002);
    chk("seq_tail_last_pc", 103, last_pc, 16'h001E);
    chk("seq_tail_frozen", 103, imem_pc, 16'h0020);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
